// File: rtl/ls_mem_arbiter.sv
// ls_mem_arbiter: round-robin owner of the shared data-memory port for the load/store FUs.
// One transaction in flight; loads are matched by tag and extended before returning.
module ls_mem_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int XLEN = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_squash,
  input  logic [NUM_REQ-1:0]      i_req_valid,
  input  logic [NUM_REQ-1:0]      i_req_is_store,
  input  logic [NUM_REQ*XLEN-1:0] i_req_addr,
  input  logic [NUM_REQ*XLEN-1:0] i_req_data,
  input  logic [NUM_REQ*3-1:0]    i_req_size,
  output logic [NUM_REQ-1:0]      o_grant,
  output logic [NUM_REQ-1:0]      o_resp_valid,
  output logic [XLEN-1:0]         o_resp_data,
  output logic                    o_busy,
  output logic [1:0]              o_mem_command,
  output logic [XLEN-1:0]         o_mem_addr,
  output logic [XLEN-1:0]         o_mem_data,
  output logic [1:0]              o_mem_size,
  input  logic [3:0]              i_mem_response,
  input  logic [3:0]              i_mem_tag,
  input  logic [XLEN-1:0]         i_mem_rdata
);
  localparam int IW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;
  state_t r_state, w_next;
  logic [IW-1:0] r_ptr, r_id, w_pick;
  logic [XLEN-1:0] r_addr, r_data, r_resp_data, w_addr, w_data, w_field, w_ext;
  logic [2:0] r_size, w_size;
  logic r_store, w_store, w_any, w_respond;
  logic [3:0] r_tag;
  logic [NUM_REQ-1:0] r_resp_valid;
  logic [1:0] w_shift;
  wire w_accept = i_mem_response != 4'd0;
  wire w_match = i_mem_tag == r_tag;
  function automatic logic [IW-1:0] wrap(input int v);
    return IW'(v % NUM_REQ);
  endfunction
  // Last assignment wins, so scanning backwards leaves the requester nearest r_ptr.
  always_comb begin
    w_pick = r_ptr;
    w_any = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--)
      if (i_req_valid[wrap(int'(r_ptr) + k)]) begin
        w_pick = wrap(int'(r_ptr) + k);
        w_any = 1'b1;
      end
  end
  always_comb begin
    w_addr = '0;
    w_data = '0;
    w_size = '0;
    w_store = 1'b0;
    for (int k = 0; k < NUM_REQ; k++)
      if (IW'(k) == w_pick) begin
        w_addr = i_req_addr[k*XLEN +: XLEN];
        w_data = i_req_data[k*XLEN +: XLEN];
        w_size = i_req_size[k*3 +: 3];
        w_store = i_req_is_store[k];
      end
  end
  assign o_grant = (r_state == IDLE && !i_squash && w_any) ? NUM_REQ'(1) << w_pick : '0;
  always_comb begin
    w_next = r_state;
    w_respond = 1'b0;
    if (r_state == IDLE) w_next = |o_grant ? ISSUE : IDLE;
    else if (r_state == ISSUE) begin
      if (w_accept) w_next = r_store ? IDLE : (i_squash ? DRAIN : WAIT);
      else if (i_squash && !r_store) w_next = IDLE;
      w_respond = w_accept && r_store;
    end else if (r_state == WAIT) begin
      w_next = w_match ? IDLE : (i_squash ? DRAIN : WAIT);
      w_respond = w_match && !i_squash;
    end else w_next = w_match ? IDLE : DRAIN;
  end
  assign w_shift = r_size[1:0] == 2'd2 ? 2'd0 : r_addr[1:0];
  assign w_field = i_mem_rdata >> {w_shift, 3'b000};
  assign w_ext = r_size[1:0] == 2'd0 ? {{(XLEN-8){w_field[7] & ~r_size[2]}}, w_field[7:0]} :
                 r_size[1:0] == 2'd1 ? {{(XLEN-16){w_field[15] & ~r_size[2]}}, w_field[15:0]} : w_field;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr <= '0;
      r_id <= '0;
      r_addr <= '0;
      r_data <= '0;
      r_size <= '0;
      r_store <= 1'b0;
      r_tag <= '0;
      r_resp_valid <= '0;
      r_resp_data <= '0;
    end else begin
      r_state <= w_next;
      r_resp_valid <= w_respond ? NUM_REQ'(1) << r_id : '0;
      r_resp_data <= (w_respond && !r_store) ? w_ext : '0;
      if (|o_grant) begin
        r_id <= w_pick;
        r_ptr <= wrap(int'(w_pick) + 1);
        r_addr <= w_addr;
        r_data <= w_data;
        r_size <= w_size;
        r_store <= w_store;
      end
      if (r_state == ISSUE && w_accept) r_tag <= i_mem_response;
    end
  end
  wire w_issue = r_state == ISSUE;
  assign o_busy = r_state != IDLE;
  assign o_mem_command = w_issue ? (r_store ? 2'd2 : 2'd1) : 2'd0;
  assign o_mem_addr = w_issue ? {r_addr[XLEN-1:2], 2'b00} : '0;
  assign o_mem_data = w_issue ? r_data << {r_addr[1:0], 3'b000} : '0;
  assign o_mem_size = w_issue ? r_size[1:0] : 2'd0;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data = r_resp_data;
endmodule

// File: tb/tb_ls_mem_arbiter.sv
// tb_ls_mem_arbiter: scenario tasks drive the arbiter; a scoreboard queue holds the
// expected {resp_valid, resp_data} of every response and is drained as pulses appear.
module tb_ls_mem_arbiter;
  logic clock = 0, reset = 1, i_squash;
  logic [1:0] i_req_valid, i_req_is_store, o_grant, o_resp_valid, o_mem_command, o_mem_size;
  logic [63:0] i_req_addr, i_req_data;
  logic [5:0] i_req_size;
  logic [31:0] o_resp_data, o_mem_addr, o_mem_data, i_mem_rdata;
  logic o_busy;
  logic [3:0] i_mem_response, i_mem_tag;
  int n_checks = 0, n_errors = 0;
  typedef struct packed {logic [1:0] vid; logic [31:0] data;} exp_t;
  exp_t sb[$];
  exp_t e;

  ls_mem_arbiter dut (
    .clock(clock), .reset(reset), .i_squash(i_squash), .i_req_valid(i_req_valid),
    .i_req_is_store(i_req_is_store), .i_req_addr(i_req_addr), .i_req_data(i_req_data),
    .i_req_size(i_req_size), .o_grant(o_grant), .o_resp_valid(o_resp_valid),
    .o_resp_data(o_resp_data), .o_busy(o_busy), .o_mem_command(o_mem_command),
    .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_size(o_mem_size),
    .i_mem_response(i_mem_response), .i_mem_tag(i_mem_tag), .i_mem_rdata(i_mem_rdata)
  );

  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (!reset && |o_resp_valid) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: resp_valid=%b data=%h, required no response", o_resp_valid, o_resp_data);
      end else begin
        e = sb.pop_front();
        if ({o_resp_valid, o_resp_data} !== {e.vid, e.data}) begin
          n_errors++;
          $display("FAIL sb_resp: got valid=%b data=%h, required valid=%b data=%h", o_resp_valid, o_resp_data, e.vid, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    i_req_valid = 0; i_req_is_store = 0; i_req_addr = 0; i_req_data = 0; i_req_size = 0;
    i_squash = 0; i_mem_response = 0; i_mem_tag = 0; i_mem_rdata = 0;
  endtask

  task automatic set_req(input int id, input logic st, input logic [31:0] a, input logic [31:0] d, input logic [2:0] sz);
    i_req_valid[id] = 1; i_req_is_store[id] = st;
    i_req_addr[id*32 +: 32] = a; i_req_data[id*32 +: 32] = d; i_req_size[id*3 +: 3] = sz;
  endtask

  task automatic do_load(input int id, input logic [31:0] addr, input logic [2:0] sz,
                         input logic [31:0] rdata, input logic [3:0] tag, input logic [31:0] exp_data);
    set_req(id, 0, addr, 0, sz);
    #1;
    n_checks++; if (o_grant !== 2'(1 << id)) begin n_errors++; $display("FAIL load_grant: got %b want %b", o_grant, 2'(1 << id)); end
    tick(); clr();
    n_checks++;
    if ({o_mem_command, o_mem_addr, o_mem_size} !== {2'd1, addr[31:2], 2'b00, sz[1:0]}) begin
      n_errors++; $display("FAIL load_issue: got cmd=%0d addr=%h size=%0d want cmd=1 addr=%h size=%0d", o_mem_command, o_mem_addr, o_mem_size, {addr[31:2], 2'b00}, sz[1:0]);
    end
    i_mem_response = tag; tick(); i_mem_response = 0;
    i_mem_tag = tag; i_mem_rdata = rdata; sb.push_back('{2'(1 << id), exp_data});
    tick(); i_mem_tag = 0;
    n_checks++; if (o_resp_valid !== 2'(1 << id)) begin n_errors++; $display("FAIL load_resp_timing: got %b want %b", o_resp_valid, 2'(1 << id)); end
    tick();
  endtask

  task automatic test_reset();
    clr(); reset = 1; tick(); tick();
    n_checks++;
    if ({o_grant, o_resp_valid, o_resp_data, o_busy, o_mem_command, o_mem_addr, o_mem_data, o_mem_size} !== '0) begin
      n_errors++; $display("FAIL reset_outputs: got grant=%b rv=%b rd=%h busy=%b cmd=%0d addr=%h data=%h size=%0d want all 0",
        o_grant, o_resp_valid, o_resp_data, o_busy, o_mem_command, o_mem_addr, o_mem_data, o_mem_size);
    end
    reset = 0;
  endtask

  task automatic test_round_robin();
    int grants = 0, cur = 0;
    logic [3:0] tag = 0, next_tag = 1;
    logic matched = 0;
    for (int c = 0; c < 13; c++) begin
      i_mem_response = 0; i_mem_tag = 0;
      if (c < 12) begin set_req(0, 0, 32'h200, 0, 3'd2); set_req(1, 0, 32'h204, 0, 3'd2); end
      else i_req_valid = 0;
      n_checks++; if ((|o_resp_valid) !== matched) begin n_errors++; $display("FAIL rr_resp_timing c%0d: got %b want pulse=%b", c, o_resp_valid, matched); end
      matched = 0;
      if (o_mem_command == 2'd1) begin
        i_mem_response = next_tag; tag = next_tag; next_tag++;
      end else if (o_busy && tag != 0) begin
        i_mem_tag = tag; i_mem_rdata = 32'h1000 + 32'(tag);
        sb.push_back('{2'(1 << cur), 32'h1000 + 32'(tag)});
        matched = 1; tag = 0;
      end
      #1;
      if (|o_grant) begin
        n_checks++; if (o_grant !== 2'(1 << (grants % 2))) begin n_errors++; $display("FAIL rr_grant %0d: got %b want %b", grants, o_grant, 2'(1 << (grants % 2))); end
        cur = o_grant[1] ? 1 : 0; grants++;
      end
      tick();
    end
    clr();
    n_checks++; if (grants !== 4) begin n_errors++; $display("FAIL rr_grant_count: got %0d want 4", grants); end
  endtask

  task automatic test_load_align();
    do_load(0, 32'h103, 3'd0, 32'h80FF_0000, 4'd3, 32'hFFFF_FF80);
    do_load(1, 32'h103, 3'd4, 32'h80FF_0000, 4'd4, 32'h0000_0080);
    do_load(0, 32'h102, 3'd1, 32'h80FF_0000, 4'd5, 32'hFFFF_80FF);
    do_load(1, 32'h102, 3'd5, 32'h80FF_0000, 4'd6, 32'h0000_80FF);
    do_load(0, 32'h103, 3'd2, 32'h80FF_1234, 4'd7, 32'h80FF_1234);
  endtask

  task automatic test_store();
    set_req(1, 1, 32'h101, 32'hAB, 3'd0); tick(); clr();
    for (int c = 0; c < 4; c++) begin
      n_checks++;
      if ({o_mem_command, o_mem_addr, o_mem_data, o_resp_valid} !== {2'd2, 32'h100, 32'h0000_AB00, 2'b00}) begin
        n_errors++; $display("FAIL store_issue c%0d: got cmd=%0d addr=%h data=%h rv=%b want cmd=2 addr=00000100 data=0000ab00 rv=00", c, o_mem_command, o_mem_addr, o_mem_data, o_resp_valid);
      end
      if (c == 3) begin i_mem_response = 4'd5; sb.push_back('{2'b10, 32'h0}); end
      tick();
    end
    clr();
    n_checks++; if ({o_resp_valid, o_busy} !== {2'b10, 1'b0}) begin n_errors++; $display("FAIL store_resp: got rv=%b busy=%b want rv=10 busy=0", o_resp_valid, o_busy); end
    tick();
  endtask

  task automatic test_squash_wait();
    set_req(0, 0, 32'h300, 0, 3'd2); tick(); clr();
    i_mem_response = 4'd7; tick(); i_mem_response = 0;
    tick();
    i_squash = 1; tick(); i_squash = 0;
    for (int c = 0; c < 4; c++) begin
      i_mem_tag = (c == 1) ? 4'd3 : 4'd0; i_mem_rdata = 32'hDEAD_BEEF;
      n_checks++; if ({o_busy, o_resp_valid, o_mem_command} !== {1'b1, 2'b00, 2'd0}) begin n_errors++; $display("FAIL drain_hold c%0d: got busy=%b rv=%b cmd=%0d want 1/00/0", c, o_busy, o_resp_valid, o_mem_command); end
      tick();
    end
    i_mem_tag = 4'd7; tick(); i_mem_tag = 0;
    n_checks++; if ({o_busy, o_resp_valid} !== 3'b000) begin n_errors++; $display("FAIL drain_exit: got busy=%b rv=%b want 0/00", o_busy, o_resp_valid); end
    do_load(1, 32'h304, 3'd2, 32'h5555_AAAA, 4'd8, 32'h5555_AAAA);
  endtask

  task automatic test_squash_races();
    set_req(0, 0, 32'h310, 0, 3'd2); tick(); clr();
    i_mem_response = 4'd9; i_squash = 1; tick(); clr();
    n_checks++; if ({o_busy, o_mem_command} !== {1'b1, 2'd0}) begin n_errors++; $display("FAIL race_accept_state: got busy=%b cmd=%0d want 1/0", o_busy, o_mem_command); end
    i_mem_tag = 4'd9; i_mem_rdata = 32'h1111_1111; tick(); clr();
    n_checks++; if ({o_busy, o_resp_valid} !== 3'b000) begin n_errors++; $display("FAIL race_accept_drain: got busy=%b rv=%b want 0/00", o_busy, o_resp_valid); end
    set_req(1, 0, 32'h314, 0, 3'd2); tick(); clr();
    i_squash = 1; tick(); i_squash = 0;
    n_checks++; if ({o_busy, o_mem_command, o_resp_valid} !== 5'b0) begin n_errors++; $display("FAIL race_issue_squash: got busy=%b cmd=%0d rv=%b want 0/0/00", o_busy, o_mem_command, o_resp_valid); end
    set_req(0, 1, 32'h322, 32'h1234, 3'd1); tick(); clr();
    i_squash = 1; tick();
    n_checks++; if ({o_mem_command, o_mem_data, o_mem_size} !== {2'd2, 32'h1234_0000, 2'd1}) begin n_errors++; $display("FAIL race_store_hold: got cmd=%0d data=%h size=%0d want 2/12340000/1", o_mem_command, o_mem_data, o_mem_size); end
    i_mem_response = 4'd4; sb.push_back('{2'b01, 32'h0}); tick(); clr();
    n_checks++; if ({o_resp_valid, o_busy} !== {2'b01, 1'b0}) begin n_errors++; $display("FAIL race_store_resp: got rv=%b busy=%b want 01/0", o_resp_valid, o_busy); end
    tick();
  endtask

  task automatic test_reset_mid_wait();
    set_req(0, 0, 32'h400, 0, 3'd2); tick(); clr();
    i_mem_response = 4'd6; tick(); i_mem_response = 0;
    reset = 1; tick(); reset = 0;
    n_checks++;
    if ({o_grant, o_resp_valid, o_resp_data, o_busy, o_mem_command, o_mem_addr, o_mem_data, o_mem_size} !== '0) begin
      n_errors++; $display("FAIL reset_wait_outputs: got grant=%b rv=%b rd=%h busy=%b cmd=%0d addr=%h want all 0", o_grant, o_resp_valid, o_resp_data, o_busy, o_mem_command, o_mem_addr);
    end
    i_mem_tag = 4'd6; i_mem_rdata = 32'hFFFF_FFFF; tick(); clr();
    n_checks++; if ({o_resp_valid, o_busy} !== 3'b000) begin n_errors++; $display("FAIL reset_late_tag: got rv=%b busy=%b want 00/0", o_resp_valid, o_busy); end
    set_req(0, 0, 32'h500, 0, 3'd2); set_req(1, 0, 32'h504, 0, 3'd2);
    #1;
    n_checks++; if (o_grant !== 2'b01) begin n_errors++; $display("FAIL reset_rr_ptr: got grant=%b want 01", o_grant); end
    tick(); clr();
    i_mem_response = 4'd2; tick(); i_mem_response = 0;
    i_mem_tag = 4'd2; i_mem_rdata = 32'h0BAD_F00D; sb.push_back('{2'b01, 32'h0BAD_F00D}); tick(); clr();
    tick();
  endtask

  initial begin
    clr();
    test_reset();
    test_round_robin();
    test_load_align();
    test_store();
    test_squash_wait();
    test_squash_races();
    test_reset_mid_wait();
    n_checks++; if (sb.size() != 0) begin n_errors++; $display("FAIL sb_leftover: got %0d pending responses want 0", sb.size()); end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
